// File: rtl/pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_barrel_shifter
//
// Purpose
//   Pipelined logarithmic shifter for the execute stage. It performs SLL, SRL,
//   SRA and ROR on a WIDTH-bit operand through log2(WIDTH) mux levels. Level k
//   shifts by 2^k when shamt[k] is set, and the levels run LSB first. A pipeline
//   register follows every STAGE_LEVELS levels, which gives a latency of
//   LAT = ceil(log2(WIDTH) / STAGE_LEVELS) cycles from accept to result.
//
//   The pipeline is a single-enable chain. When adv = !out_valid || out_ready,
//   every stage loads from its predecessor. Otherwise every stage holds. Bubbles
//   are not collapsed, so order is preserved and no op is dropped or repeated.
//
// Parameters
//   WIDTH         operand width; power of two, >= 8
//   STAGE_LEVELS  mux levels per pipeline stage, 1..log2(WIDTH)
//   TAG_W         width of the opaque sideband tag
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset; flushes every stage
//   in_valid   in   an op is presented
//   in_ready   out  the block accepts an op this cycle (combinational, = adv)
//   in_data    in   operand
//   in_shamt   in   unsigned shift amount, log2(WIDTH) bits
//   in_op      in   00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_tag     in   tag returned unchanged with the result
//   out_valid  out  a result is presented
//   out_ready  in   downstream takes the result
//   out_data   out  result
//   out_tag    out  tag of the result
//   carry_out  out  last bit shifted out (only with SHIFTER_CARRY_EN)
//
// Configuration
//   SHIFTER_CARRY_EN  when defined, adds carry_out. The carry is registered
//                     alongside out_data and follows these rules:
//                     SLL -> a[WIDTH-shamt]; SRL/SRA -> a[shamt-1];
//                     ROR -> out_data[WIDTH-1]; 0 when shamt == 0.
// -----------------------------------------------------------------------------
module pipelined_barrel_shifter #(
    parameter int WIDTH        = 32,
    parameter int STAGE_LEVELS = 2,
    parameter int TAG_W        = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_shamt,
    input  logic [1:0]               in_op,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [TAG_W-1:0]         out_tag
`ifdef SHIFTER_CARRY_EN
    ,
    output logic                     carry_out
`endif
);

    localparam int LEVELS = $clog2(WIDTH);
    localparam int LAT    = (LEVELS + STAGE_LEVELS - 1) / STAGE_LEVELS;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    // -------------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // -------------------------------------------------------------------------
    if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
        $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 8");
    end
    if ((STAGE_LEVELS < 1) || (STAGE_LEVELS > LEVELS)) begin : g_bad_stage_levels
        $error("pipelined_barrel_shifter: STAGE_LEVELS must be in 1..log2(WIDTH)");
    end

    // -------------------------------------------------------------------------
    // Stage registers. Index s is the register after stage s. The last entry
    // drives the outputs directly, so every output is registered.
    // -------------------------------------------------------------------------
    logic              st_valid [LAT];
    logic [WIDTH-1:0]  st_data  [LAT];
    logic [TAG_W-1:0]  st_tag   [LAT];
    shift_op_e         st_op    [LAT];
    logic [LEVELS-1:0] st_shamt [LAT];

    // Stage inputs: the input port for stage 0, the previous register otherwise.
    logic              src_valid [LAT];
    logic [WIDTH-1:0]  src_data  [LAT];
    logic [TAG_W-1:0]  src_tag   [LAT];
    shift_op_e         src_op    [LAT];
    logic [LEVELS-1:0] src_shamt [LAT];

    // Output of every mux level after its conditional shift.
    logic [WIDTH-1:0]  lvl_data  [LEVELS];

`ifdef SHIFTER_CARRY_EN
    logic              st_carry  [LAT];
    logic              src_carry [LAT];
    logic              lvl_carry [LEVELS];
`endif

    // -------------------------------------------------------------------------
    // Handshake. Every stage shares one enable, and a result that is stalled
    // at the output freezes the whole chain, bubbles included.
    // -------------------------------------------------------------------------
    logic adv;

    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    assign out_valid = st_valid[LAT-1];
    assign out_data  = st_data[LAT-1];
    assign out_tag   = st_tag[LAT-1];
`ifdef SHIFTER_CARRY_EN
    assign carry_out = st_carry[LAT-1];
`endif

    // -------------------------------------------------------------------------
    // Mux levels. Level k shifts by 2^k and reads its op and shamt from the
    // stage it belongs to. The first level of a stage reads the stage input.
    // Later levels read the previous level.
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < LEVELS; k++) begin : g_level
        localparam int S  = k / STAGE_LEVELS;
        localparam int SH = 1 << k;

        logic [WIDTH-1:0] d_in;
        logic [WIDTH-1:0] d_sh;

        if ((k % STAGE_LEVELS) == 0) begin : g_first
            assign d_in = src_data[S];
        end else begin : g_chain
            assign d_in = lvl_data[k-1];
        end

        // NOTE: each combinational output gets a default before the case, so
        // no path through the block can leave it unassigned and infer a latch.
        always_comb begin
            d_sh = d_in;
            unique case (src_op[S])
                OP_SLL: d_sh = d_in << SH;
                OP_SRL: d_sh = d_in >> SH;
                // The sign bit is invariant under arithmetic right shifts, so
                // each level can take it from its own input.
                OP_SRA: d_sh = $signed(d_in) >>> SH;
                OP_ROR: d_sh = (d_in >> SH) | (d_in << (WIDTH - SH));
            endcase
        end

        assign lvl_data[k] = src_shamt[S][k] ? d_sh : d_in;

`ifdef SHIFTER_CARRY_EN
        // Each active level replaces the carry with the last bit it pushes out.
        // Inactive levels pass the carry through. The final value is therefore
        // the bit shifted out by the highest active level, which is the last bit
        // lost over the whole shift. For ROR, a[SH-1] is the bit that wraps into
        // the MSB, so the same rule yields out_data[WIDTH-1].
        logic c_in;
        logic c_sh;

        if ((k % STAGE_LEVELS) == 0) begin : g_first_c
            assign c_in = src_carry[S];
        end else begin : g_chain_c
            assign c_in = lvl_carry[k-1];
        end

        always_comb begin
            c_sh = c_in;
            unique case (src_op[S])
                OP_SLL:                 c_sh = d_in[WIDTH-SH];
                OP_SRL, OP_SRA, OP_ROR: c_sh = d_in[SH-1];
            endcase
        end

        assign lvl_carry[k] = src_shamt[S][k] ? c_sh : c_in;
`endif
    end

    // -------------------------------------------------------------------------
    // Pipeline stages
    // -------------------------------------------------------------------------
    for (genvar s = 0; s < LAT; s++) begin : g_stage
        // Index of the last mux level that belongs to this stage.
        localparam int LAST_LVL =
            (((s + 1) * STAGE_LEVELS) < LEVELS ? ((s + 1) * STAGE_LEVELS) : LEVELS) - 1;

        if (s == 0) begin : g_src_port
            assign src_valid[0] = in_valid;
            assign src_data[0]  = in_data;
            assign src_tag[0]   = in_tag;
            assign src_op[0]    = shift_op_e'(in_op);
            assign src_shamt[0] = in_shamt;
`ifdef SHIFTER_CARRY_EN
            assign src_carry[0] = 1'b0;
`endif
        end else begin : g_src_reg
            assign src_valid[s] = st_valid[s-1];
            assign src_data[s]  = st_data[s-1];
            assign src_tag[s]   = st_tag[s-1];
            assign src_op[s]    = st_op[s-1];
            assign src_shamt[s] = st_shamt[s-1];
`ifdef SHIFTER_CARRY_EN
            assign src_carry[s] = st_carry[s-1];
`endif
        end

        // NOTE: state is updated with non-blocking assignments, so every stage
        // samples its predecessor's pre-edge value regardless of process order.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                // NOTE: the data, tag and op fields are cleared along with
                // valid, because out_data and out_tag must read 0 after reset.
                // Clearing only valid would leave stale data visible.
                st_valid[s] <= 1'b0;
                st_data[s]  <= '0;
                st_tag[s]   <= '0;
                st_op[s]    <= OP_SLL;
                st_shamt[s] <= '0;
`ifdef SHIFTER_CARRY_EN
                st_carry[s] <= 1'b0;
`endif
            end else if (adv) begin
                // Stage 0 takes in_valid as-is. Since in_ready == adv, this
                // is exactly the accept condition.
                st_valid[s] <= src_valid[s];
                st_data[s]  <= lvl_data[LAST_LVL];
                st_tag[s]   <= src_tag[s];
                st_op[s]    <= src_op[s];
                st_shamt[s] <= src_shamt[s];
`ifdef SHIFTER_CARRY_EN
                st_carry[s] <= lvl_carry[LAST_LVL];
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipelined_barrel_shifter
//
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=32, STAGE_LEVELS=2).
// The driver pushes the hand-computed expected result for each accepted op.
// A separate monitor pops and compares on every output transfer. The monitor
// also checks in_ready, output stability under backpressure, and the absence of
// gaps in the drain after a stall.
// -----------------------------------------------------------------------------
module tb_pipelined_barrel_shifter;

    localparam int WIDTH = 32;
    localparam int SL    = 2;
    localparam int TAG_W = 4;
    localparam int LAT   = 3;
    localparam int NVEC  = 19;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [4:0]       in_shamt;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef SHIFTER_CARRY_EN
    logic             carry_out;
`endif

    pipelined_barrel_shifter #(
        .WIDTH        (WIDTH),
        .STAGE_LEVELS (SL),
        .TAG_W        (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef SHIFTER_CARRY_EN
        ,
        .carry_out (carry_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  sh;
        logic [1:0]  op;
        logic [31:0] res;
        logic        c;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        c;
        bit          chk_lat;
        int          acc_cyc;
    } exp_t;

    vec_t vecs [NVEC];
    exp_t sb [$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- out_ready control ----------------
    // 0: always 1, 1: toggle every cycle, 2: low for stall_left cycles then 1,
    // 3: always 0
    int rmode      = 0;
    int stall_left = 0;

    initial out_ready = 1'b1;
    always @(negedge clk) begin
        case (rmode)
            1:       out_ready = ~out_ready;
            2:       begin
                         if (stall_left > 0) begin
                             out_ready = 1'b0;
                             stall_left--;
                         end else begin
                             out_ready = 1'b1;
                         end
                     end
            3:       out_ready = 1'b0;
            default: out_ready = 1'b1;
        endcase
    end

    // ---------------- monitor ----------------
    bit          gap_mode  = 0;
    bit          gap_armed = 0;
    bit          held      = 0;
    logic [31:0] held_data;
    logic [3:0]  held_tag;
    exp_t        m_exp;

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                held      = 0;
                gap_armed = 0;
            end else begin
                check("in_ready", in_ready, !out_valid || out_ready);
                if (held) begin
                    check("hold_valid", out_valid, 1'b1);
                    check("hold_data", out_data, held_data);
                    check("hold_tag", out_tag, held_tag);
                end
                if (gap_armed) begin
                    if (sb.size() > 0) check("no_gap", out_valid, 1'b1);
                    else gap_armed = 0;
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got data %h tag %h expected none",
                                 out_data, out_tag);
                    end else begin
                        m_exp = sb.pop_front();
                        check("data", out_data, m_exp.data);
                        check("tag", out_tag, m_exp.tag);
`ifdef SHIFTER_CARRY_EN
                        check("carry", carry_out, m_exp.c);
`endif
                        if (m_exp.chk_lat) check("latency", cyc - m_exp.acc_cyc, LAT);
                        if (gap_mode) gap_armed = 1;
                    end
                end
                held      = out_valid && !out_ready;
                held_data = out_data;
                held_tag  = out_tag;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input int vi, input logic [3:0] tag, input bit lat);
        bit acc = 0;
        int e   = 0;
        exp_t x;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = vecs[vi].a;
        in_shamt = vecs[vi].sh;
        in_op    = vecs[vi].op;
        in_tag   = tag;
        for (int w = 0; w < 200; w++) begin
            #1;
            acc = in_ready && rst_n;
            e   = cyc;
            @(posedge clk);
            if (acc) begin
                x.data    = vecs[vi].res;
                x.tag     = tag;
                x.c       = vecs[vi].c;
                x.chk_lat = lat;
                x.acc_cyc = e;
                sb.push_back(x);
                break;
            end
            @(negedge clk);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept for vector %0d expected accept", vi);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int w = 0; w < 300; w++) begin
            @(negedge clk);
            #3;
            if (sb.size() == 0) break;
        end
        check(name, sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        //          a              sh     op     result         carry
        vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0};
        vecs[1]  = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001, 1'b0};
        vecs[3]  = '{32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 1'b0};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF, 1'b0};
        vecs[7]  = '{32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF, 1'b0};
        vecs[8]  = '{32'h1234_5678, 5'd4,  2'b00, 32'h2345_6780, 1'b1};
        vecs[9]  = '{32'h1234_5678, 5'd8,  2'b01, 32'h0012_3456, 1'b0};
        vecs[10] = '{32'hF000_0000, 5'd4,  2'b10, 32'hFF00_0000, 1'b0};
        vecs[11] = '{32'h1234_5678, 5'd16, 2'b11, 32'h5678_1234, 1'b0};
        vecs[12] = '{32'h7FFF_FFFF, 5'd31, 2'b10, 32'h0000_0000, 1'b1};
        vecs[13] = '{32'hFFFF_FFFF, 5'd1,  2'b00, 32'hFFFF_FFFE, 1'b1};
        vecs[14] = '{32'h0000_0001, 5'd1,  2'b11, 32'h8000_0000, 1'b1};
        vecs[15] = '{32'h8000_0001, 5'd1,  2'b01, 32'h4000_0000, 1'b1};
        vecs[16] = '{32'h8000_0000, 5'd1,  2'b10, 32'hC000_0000, 1'b0};
        vecs[17] = '{32'h0000_0003, 5'd30, 2'b00, 32'hC000_0000, 1'b0};
        vecs[18] = '{32'h8000_0000, 5'd31, 2'b11, 32'h0000_0001, 1'b0};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_shamt = '0;
        in_op    = '0;
        in_tag   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("rst_in_ready", in_ready, 1'b1);

        // Single op with latency measurement
        send(0, 4'd5, 1'b1);
        idle();
        wait_drain("drain_single");

        // Directed vectors back-to-back, out_ready held high
        for (int i = 1; i < NVEC; i++) send(i, 4'(i), 1'b0);
        idle();
        wait_drain("drain_directed");

        // Six-op stream into a stalled output, then drain with no gaps
        gap_mode   = 1;
        stall_left = 8;
        rmode      = 2;
        for (int i = 0; i < 6; i++) send(8 + i, 4'(i), 1'b0);
        idle();
        wait_drain("drain_stall");
        gap_mode = 0;
        rmode    = 0;

        // Stream with out_ready toggling every cycle
        rmode = 1;
        for (int i = 0; i < NVEC; i++) send(i, 4'(15 - (i % 16)), 1'b0);
        idle();
        wait_drain("drain_toggle");
        rmode = 0;
        repeat (2) @(negedge clk);

        // Mid-flight reset: three accepted ops are discarded, and an op
        // presented during reset is not accepted.
        rmode = 3;
        for (int i = 0; i < 3; i++) send(8 + i, 4'(i), 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        rmode     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_00FF;
        in_shamt  = 5'd1;
        in_op     = 2'b00;
        in_tag    = 4'hF;
        sb.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #3;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_out_data", out_data, 32'h0);
        check("flush_out_tag", out_tag, 4'h0);
        check("flush_in_ready", in_ready, 1'b1);
        repeat (10) @(negedge clk);

        // A normal op goes through after the flush
        send(3, 4'd9, 1'b1);
        idle();
        wait_drain("drain_post_reset");
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
